pwm_light_driver: RTL

- Consumes the slow ramping brightness count from the up/down triangle counter and converts it into a fixed-period PWM waveform driving the LED.
- Duty is sampled only at period boundaries, so a ramping input never glitches a pulse mid-period.
- An enable with graceful stop always finishes the current period before the output parks at its inactive level.

---
 rtl/pwm_light_driver.sv | 61 ++++++
 1 files changed

// File: rtl/pwm_light_driver.sv
// pwm_light_driver: fixed-period PWM with boundary-latched, clamped duty and graceful stop
module pwm_light_driver #(
  parameter int unsigned PERIOD      = 10,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] duty,
  output logic        pwm_out,
  output logic        period_start,
  output logic        busy,
  output logic [31:0] duty_latched
);
  localparam logic [31:0] P    = 32'(PERIOD);
  localparam logic [31:0] LAST = 32'(PERIOD - 1);
  localparam logic        OFF  = ~ACTIVE_HIGH;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t      r_state;
  logic [31:0] r_phase, r_duty;
  logic        r_pwm, r_ps, r_busy;
  logic [31:0] w_clamp, w_next;
  logic        w_edge;
  assign w_clamp = duty > P ? P : duty;
  assign w_next  = r_phase + 32'd1;
  assign w_edge  = r_state == IDLE || r_phase == LAST;
  assign pwm_out      = r_pwm;
  assign period_start = r_ps;
  assign busy         = r_busy;
  assign duty_latched = r_duty;
  // At a period edge (or from idle) either start a new period or park; otherwise keep counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_duty  <= '0;
      r_pwm   <= OFF;
      r_ps    <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_edge && en) begin
      r_state <= RUN;
      r_phase <= '0;
      r_duty  <= w_clamp;
      r_pwm   <= (w_clamp != 32'd0) ^ OFF;
      r_ps    <= 1'b1;
      r_busy  <= 1'b1;
    end else if (w_edge) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_pwm   <= OFF;
      r_ps    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= en ? RUN : STOP;
      r_phase <= w_next;
      r_pwm   <= (w_next < r_duty) ^ OFF;
      r_ps    <= 1'b0;
      r_busy  <= 1'b1;
    end
  end
endmodule
